// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the external combinational ALU: reads operands from a
// small register file, issues them for one cycle, captures and returns the result.
module alu_cmd_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREG)-1:0]  cmd_src_a,
  input  logic [$clog2(NREG)-1:0]  cmd_src_b,
  input  logic [$clog2(NREG)-1:0]  cmd_dst,
  input  logic                     cmd_wr_en,
  input  logic [DATA_W-1:0]        cmd_imm,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [2:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [$clog2(NREG)-1:0]  res_dst,
  output logic                     res_zero,
  output logic [CNT_W-1:0]         cmd_count
);

  localparam int AW = $clog2(NREG);

  // state  | meaning
  // IDLE   | ready for a command
  // ISSUE  | operands on the ALU inputs, result captured on the next edge
  // RESP   | response held until res_ready
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic                wr_en_q, wr_en_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [AW-1:0]       res_dst_q, res_dst_d;
  logic                res_zero_q, res_zero_d;
  logic [CNT_W-1:0]    cmd_count_q, cmd_count_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    wr_en_d     = wr_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    res_zero_d  = res_zero_q;
    cmd_count_d = cmd_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            regs_d[cmd_dst] = cmd_imm;
            res_data_d      = cmd_imm;
            res_dst_d       = cmd_dst;
            res_zero_d      = (cmd_imm == '0);
            res_valid_d     = 1'b1;
            state_d         = S_RESP;
          end else begin
            alu_a_d  = regs_q[cmd_src_a];
            alu_b_d  = regs_q[cmd_src_b];
            alu_op_d = cmd_op;
            dst_d    = cmd_dst;
            wr_en_d  = cmd_wr_en;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        res_data_d  = alu_result;
        res_dst_d   = dst_q;
        res_zero_d  = (alu_result == '0);
        res_valid_d = 1'b1;
        if (wr_en_q) regs_d[dst_q] = alu_result;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cmd_count_d = cmd_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      dst_q       <= '0;
      wr_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      res_zero_q  <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      wr_en_q     <= wr_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      res_zero_q  <= res_zero_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_dst   = res_dst_q;
  assign res_zero  = res_zero_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic       cmd_wr_en = 1'b0;
  logic [3:0] cmd_imm = '0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_data;
  logic [1:0] res_dst;
  logic       res_zero;
  logic [7:0] cmd_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(4), .NREG(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_wr_en(cmd_wr_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .res_zero(res_zero), .cmd_count(cmd_count)
  );

  // Bench ALU: 000/111 return 0
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b001: alu_result = alu_a + alu_b;
      3'b010: alu_result = alu_a - alu_b;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a ^ alu_b;
      3'b110: alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the command driven; returns just after the accept edge.
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      cmd_valid = 1'b0;
      chk("accept_timeout", 32'(ok), 32'd1);
    end
  endtask

  task automatic do_load(input logic [1:0] d, input logic [3:0] imm);
    @(negedge clk);
    cmd_load = 1'b1; cmd_dst = d; cmd_imm = imm; cmd_valid = 1'b1; res_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("load_valid", 32'(res_valid), 32'd1);
    chk("load_data", 32'(res_data), 32'(imm));
    chk("load_dst", 32'(res_dst), 32'(d));
    @(negedge clk);
    exp_count++;
    chk("load_count", 32'(cmd_count), 32'(exp_count));
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] d, input logic wr,
                        input int ea, input int eb, input int er);
    @(negedge clk);
    cmd_load = 1'b0; cmd_op = op; cmd_src_a = sa; cmd_src_b = sb;
    cmd_dst = d; cmd_wr_en = wr; cmd_valid = 1'b1; res_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    chk($sformatf("op%0d_issue_a", op), 32'(alu_a), 32'(ea));
    chk($sformatf("op%0d_issue_b", op), 32'(alu_b), 32'(eb));
    chk($sformatf("op%0d_issue_op", op), 32'(alu_op), 32'(op));
    chk($sformatf("op%0d_early_valid", op), 32'(res_valid), 32'd0);
    chk($sformatf("op%0d_issue_ready", op), 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("op%0d_valid", op), 32'(res_valid), 32'd1);
    chk($sformatf("op%0d_data", op), 32'(res_data), 32'(er));
    chk($sformatf("op%0d_dst", op), 32'(res_dst), 32'(d));
    chk($sformatf("op%0d_zero", op), 32'(res_zero), 32'(er == 0));
    @(negedge clk);
    exp_count++;
    chk($sformatf("op%0d_done_valid", op), 32'(res_valid), 32'd0);
    chk($sformatf("op%0d_done_ready", op), 32'(cmd_ready), 32'd1);
    chk($sformatf("op%0d_count", op), 32'(cmd_count), 32'(exp_count));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);

    do_load(2'd0, 4'd5);
    do_load(2'd1, 4'd3);
    chk("loads_count", 32'(cmd_count), 32'd2);

    do_alu(3'b001, 2'd0, 2'd1, 2'd2, 1'b1, 5, 3, 8);     // R2 = 8
    do_alu(3'b011, 2'd2, 2'd2, 2'd0, 1'b0, 8, 8, 8);     // reads new R2
    do_alu(3'b010, 2'd1, 2'd0, 2'd3, 1'b1, 3, 5, 'hE);   // R3 = E (wrap)
    do_alu(3'b000, 2'd0, 2'd1, 2'd1, 1'b0, 5, 3, 0);
    do_alu(3'b111, 2'd0, 2'd1, 2'd1, 1'b0, 5, 3, 0);
    do_alu(3'b100, 2'd0, 2'd1, 2'd0, 1'b0, 5, 3, 7);     // no write-back
    do_alu(3'b011, 2'd0, 2'd0, 2'd1, 1'b0, 5, 5, 5);     // R0 still 5
    do_alu(3'b011, 2'd3, 2'd3, 2'd1, 1'b0, 'hE, 'hE, 'hE);

    // Backpressure: hold response while a load is pending
    @(negedge clk);
    cmd_load = 1'b0; cmd_op = 3'b001; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    cmd_dst = 2'd2; cmd_wr_en = 1'b0; cmd_valid = 1'b1; res_ready = 1'b0;
    wait_accept();
    @(negedge clk);
    cmd_load = 1'b1; cmd_dst = 2'd1; cmd_imm = 4'd7; cmd_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'd8);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_count", 32'(cmd_count), 32'(exp_count));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    chk("bp_hs_valid", 32'(res_valid), 32'd0);
    chk("bp_hs_count", 32'(cmd_count), 32'(exp_count));
    chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_valid", 32'(res_valid), 32'd1);
    chk("bp_next_data", 32'(res_data), 32'd7);
    chk("bp_next_dst", 32'(res_dst), 32'd1);
    @(negedge clk);
    exp_count++;
    chk("bp_next_count", 32'(cmd_count), 32'(exp_count));

    // Reset in ISSUE of an add into R2 (E + 5 = 3)
    @(negedge clk);
    cmd_load = 1'b0; cmd_op = 3'b001; cmd_src_a = 2'd3; cmd_src_b = 2'd0;
    cmd_dst = 2'd2; cmd_wr_en = 1'b1; cmd_valid = 1'b1; res_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("mid_issue_a", 32'(alu_a), 32'hE);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_count", 32'(cmd_count), 32'd0);
    chk("mid_alu_a", 32'(alu_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_resp", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    do_alu(3'b100, 2'd2, 2'd2, 2'd0, 1'b0, 0, 0, 0);     // R2 cleared

    // Continuous loads to wrap the counter
    cmd_load = 1'b1; cmd_dst = 2'd0; cmd_imm = 4'd5; cmd_valid = 1'b1; res_ready = 1'b1;
    n = 255 - exp_count;
    repeat (2 * n) @(posedge clk);
    @(negedge clk);
    chk("wrap_max", 32'(cmd_count), 32'd255);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wrap_zero", 32'(cmd_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
